// File: rtl/game_pkg.sv
// Shared definitions for the Minesweeper game controller: state encoding and timing constants.
package game_pkg;

  localparam int unsigned ST_W        = 3;
  localparam int unsigned SEC_W       = 10;
  localparam int unsigned LW          = 3;
  localparam int unsigned PENALTY_CYC = 16;
  localparam int unsigned PEN_W       = $clog2(PENALTY_CYC);
  localparam int unsigned SEC_MAX     = 999;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_PLAYING = 3'd1,
    ST_PENALTY = 3'd2,
    ST_WON     = 3'd3,
    ST_LOST    = 3'd4
  } state_e;

endpackage

// File: rtl/sec_timer.sv
// Elapsed-time counter: prescaler of CLK_DIV clocks feeding a seconds count that saturates at SEC_MAX.
module sec_timer
  import game_pkg::*;
#(
  parameter int unsigned CLK_DIV = 25_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic             tick,
  output logic [SEC_W-1:0] seconds
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0]    presc_q, presc_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic             tick_q, tick_d;

  // Clear dominates enable so a restart always lands on a clean second boundary.
  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    tick_d  = 1'b0;
    if (clr) begin
      presc_d = '0;
      sec_d   = '0;
    end else if (en) begin
      if (presc_q == PW'(CLK_DIV - 1)) begin
        presc_d = '0;
        tick_d  = 1'b1;
        if (sec_q != SEC_W'(SEC_MAX)) sec_d = sec_q + SEC_W'(1);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      sec_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      tick_q  <= tick_d;
    end
  end

  assign tick    = tick_q;
  assign seconds = sec_q;

endmodule

// File: rtl/game_ctrl_param.sv
// Minesweeper game controller: gates play on adjacency readiness, tracks lives, flags and
// elapsed time, and decides win/loss with restart support.
module game_ctrl_param
  import game_pkg::*;
#(
  parameter  int unsigned GRID_SIZE  = 8,
  parameter  int unsigned NUM_MINES  = 10,
  parameter  int unsigned LIVES      = 1,
  parameter  int unsigned CLK_DIV    = 25_000_000,
  parameter  int unsigned TIME_LIMIT = 999,
  localparam int unsigned TOTAL      = GRID_SIZE * GRID_SIZE,
  localparam int unsigned CW         = $clog2(TOTAL + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                restart,
  input  logic                adj_done,
  input  logic [CW-1:0]       reveal_count,
  input  logic                mine_hit,
  input  logic                flag_set,
  input  logic                flag_clr,
  output logic [ST_W-1:0]     state,
  output logic                playing,
  output logic                board_clear,
  output logic                endgame,
  output logic                win,
  output logic [LW-1:0]       lives_left,
  output logic signed [CW:0]  flags_left,
  output logic [SEC_W-1:0]    seconds
);

  localparam int unsigned FW     = CW + 1;
  localparam int          FL_MAX = int'(NUM_MINES);
  localparam int          FL_MIN = int'(NUM_MINES) - int'(TOTAL);

  state_e                 state_q, state_d;
  logic [LW-1:0]          lives_q, lives_d;
  logic signed [FW-1:0]   flags_q, flags_d;
  logic [PEN_W-1:0]       pen_q, pen_d;
  logic                   playing_q, playing_d;
  logic                   bclr_q, bclr_d;
  logic                   endgame_q, endgame_d;
  logic                   win_q, win_d;
  logic                   timer_en_c, timer_clr_c, timeout_c;
  logic                   tick_unused;

  assign timer_en_c = (state_q == ST_PLAYING) || (state_q == ST_PENALTY);
  assign timeout_c  = (TIME_LIMIT != 0) && (seconds >= SEC_W'(TIME_LIMIT));

  sec_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (timer_en_c),
    .clr     (timer_clr_c),
    .tick    (tick_unused),
    .seconds (seconds)
  );

  // Next-state, counters and registered outputs; restart overrides everything.
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    flags_d     = flags_q;
    pen_d       = pen_q;
    bclr_d      = 1'b0;
    timer_clr_c = 1'b0;
    if (restart) begin
      state_d     = ST_IDLE;
      lives_d     = LW'(LIVES);
      flags_d     = FW'(FL_MAX);
      pen_d       = '0;
      bclr_d      = 1'b1;
      timer_clr_c = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start && adj_done) state_d = ST_PLAYING;
        ST_PLAYING: begin
          if (mine_hit) begin
            lives_d = lives_q - LW'(1);
            pen_d   = '0;
            state_d = (lives_q == LW'(1)) ? ST_LOST : ST_PENALTY;
          end else if (timeout_c) begin
            state_d = ST_LOST;
          end else if (reveal_count == CW'(TOTAL - NUM_MINES)) begin
            state_d = ST_WON;
          end
        end
        ST_PENALTY: begin
          if (pen_q == PEN_W'(PENALTY_CYC - 1)) begin
            state_d = ST_PLAYING;
            pen_d   = '0;
          end else begin
            pen_d = pen_q + PEN_W'(1);
          end
        end
        default: ;
      endcase
      // Flags move only while the renderer is accepting input; placed count saturates at 0 and TOTAL.
      if (playing_q && (flag_set != flag_clr)) begin
        if (flag_set && (flags_q != FW'(FL_MIN)))      flags_d = flags_q - FW'(1);
        else if (flag_clr && (flags_q != FW'(FL_MAX))) flags_d = flags_q + FW'(1);
      end
    end
    playing_d = (state_d == ST_PLAYING);
    endgame_d = (state_d == ST_WON) || (state_d == ST_LOST);
    win_d     = (state_d == ST_WON);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      lives_q   <= LW'(LIVES);
      flags_q   <= FW'(FL_MAX);
      pen_q     <= '0;
      playing_q <= 1'b0;
      bclr_q    <= 1'b0;
      endgame_q <= 1'b0;
      win_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      flags_q   <= flags_d;
      pen_q     <= pen_d;
      playing_q <= playing_d;
      bclr_q    <= bclr_d;
      endgame_q <= endgame_d;
      win_q     <= win_d;
    end
  end

  assign state       = state_q;
  assign playing     = playing_q;
  assign board_clear = bclr_q;
  assign endgame     = endgame_q;
  assign win         = win_q;
  assign lives_left  = lives_q;
  assign flags_left  = flags_q;

endmodule
